// File: rtl/act_buff_ctrl.sv
// rtl/act_buff_ctrl.sv - ping-pong write/read scheduler for the per-row activation buffer SRAM bank
module act_buff_ctrl #(
    parameter int nb_pe_row            = 16,
    parameter int compressed_act_width = 17,
    parameter int mem_depth            = 768,
    parameter int half_depth           = mem_depth / 2,
    parameter int addr_width           = $clog2(mem_depth),
    parameter int len_width            = $clog2(half_depth + 1),
    parameter int row_width            = $clog2(nb_pe_row)
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         wr_valid,
    output logic                                         wr_ready,
    input  logic [row_width-1:0]                         wr_row,
    input  logic [compressed_act_width-1:0]              wr_data,
    input  logic                                         wr_last,
    input  logic                                         rd_start,
    input  logic [len_width-1:0]                         rd_len,
    output logic [nb_pe_row-1:0]                         wEn_AH,
    output logic [nb_pe_row*addr_width-1:0]              wAddr,
    output logic [nb_pe_row*compressed_act_width-1:0]    mem_data_in_all_rows,
    output logic [nb_pe_row-1:0]                         rEn_AH,
    output logic [nb_pe_row*addr_width-1:0]              rAddr,
    output logic                                         act_valid,
    output logic                                         rd_busy,
    output logic                                         rd_done,
    output logic [1:0]                                   half_full,
    output logic                                         wr_overflow
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [addr_width-1:0] half_base = addr_width'(half_depth);
    localparam logic [len_width-1:0]  half_len  = len_width'(half_depth);

    logic [1:0]                            state;
    logic [1:0]                            half_st;
    logic                                  wr_half;
    logic                                  rd_half;
    logic [len_width-1:0]                  wcnt [nb_pe_row];
    logic [len_width-1:0]                  rcnt;
    logic [len_width-1:0]                  rlen;
    logic                                  ren_q;
    logic                                  ren_last_q;
    logic                                  av_pipe;
    logic                                  av_last_pipe;
    logic                                  act_last;
    logic [addr_width-1:0]                 raddr_q;
    logic [compressed_act_width-1:0]       wdata_q;

    logic wr_hs;
    logic commit;
    logic wr_ovf_now;
    logic rd_full_now;

    assign wr_ready    = ~half_st[wr_half];
    assign wr_hs       = wr_valid & wr_ready;
    assign commit      = wr_hs & wr_last;
    assign wr_ovf_now  = (wcnt[wr_row] == half_len);
    // A commit landing this cycle on the half the reader waits for counts as full.
    assign rd_full_now = half_st[rd_half] | (commit & (wr_half == rd_half));

    assign rEn_AH               = {nb_pe_row{ren_q}};
    assign rAddr                = {nb_pe_row{raddr_q}};
    assign mem_data_in_all_rows = {nb_pe_row{wdata_q}};
    assign rd_busy              = (state != S_IDLE);
    assign half_full            = half_st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_half     <= 1'b0;
            wEn_AH      <= '0;
            wAddr       <= '0;
            wdata_q     <= '0;
            wr_overflow <= 1'b0;
            for (int r = 0; r < nb_pe_row; r++) wcnt[r] <= '0;
        end else begin
            wEn_AH <= '0;
            if (wr_hs) begin
                wdata_q <= wr_data;
                if (wr_ovf_now) begin
                    wr_overflow <= 1'b1;
                end else begin
                    wEn_AH[wr_row] <= 1'b1;
                    wAddr[int'(wr_row)*addr_width +: addr_width] <=
                        (wr_half ? half_base : '0) + addr_width'(wcnt[wr_row]);
                    wcnt[wr_row] <= wcnt[wr_row] + 1'b1;
                end
                if (wr_last) begin
                    for (int r = 0; r < nb_pe_row; r++) wcnt[r] <= '0;
                    wr_half <= ~wr_half;
                end
            end
        end
    end

    // Commit and release never target the same half: one is EMPTY, the other FULL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_st <= 2'b00;
            rd_half <= 1'b0;
        end else begin
            if (commit) half_st[wr_half] <= 1'b1;
            if (ren_last_q) begin
                half_st[rd_half] <= 1'b0;
                rd_half          <= ~rd_half;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            rcnt         <= '0;
            rlen         <= '0;
            ren_q        <= 1'b0;
            ren_last_q   <= 1'b0;
            raddr_q      <= '0;
            av_pipe      <= 1'b0;
            av_last_pipe <= 1'b0;
            act_valid    <= 1'b0;
            act_last     <= 1'b0;
            rd_done      <= 1'b0;
        end else begin
            ren_q        <= 1'b0;
            ren_last_q   <= 1'b0;
            av_pipe      <= ren_q;
            act_valid    <= av_pipe;
            av_last_pipe <= ren_last_q;
            act_last     <= av_last_pipe;
            rd_done      <= act_last;
            case (state)
                S_IDLE: begin
                    if (rd_start && rd_len != '0) begin
                        rlen  <= (rd_len > half_len) ? half_len : rd_len;
                        rcnt  <= '0;
                        state <= rd_full_now ? S_READ : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rd_full_now) state <= S_READ;
                end
                S_READ: begin
                    ren_q   <= 1'b1;
                    raddr_q <= (rd_half ? half_base : '0) + addr_width'(rcnt);
                    rcnt    <= rcnt + 1'b1;
                    if (rcnt == rlen - 1'b1) begin
                        ren_last_q <= 1'b1;
                        state      <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (act_last) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_act_buff_ctrl.sv
// tb/tb_act_buff_ctrl.sv - randomized self-checking bench for act_buff_ctrl against a ping-pong model
module tb_act_buff_ctrl;

    localparam int NR = 16;
    localparam int DW = 17;
    localparam int AW = 10;
    localparam int HD = 384;
    localparam int LW = 9;
    localparam logic [630:0] RST_VEC = {1'b1, 630'd0};

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 wr_valid = 1'b0;
    logic                 wr_ready;
    logic [3:0]           wr_row = '0;
    logic [DW-1:0]        wr_data = '0;
    logic                 wr_last = 1'b0;
    logic                 rd_start = 1'b0;
    logic [LW-1:0]        rd_len = '0;
    logic [NR-1:0]        wEn_AH;
    logic [NR*AW-1:0]     wAddr;
    logic [NR*DW-1:0]     mem_data_in_all_rows;
    logic [NR-1:0]        rEn_AH;
    logic [NR*AW-1:0]     rAddr;
    logic                 act_valid;
    logic                 rd_busy;
    logic                 rd_done;
    logic [1:0]           half_full;
    logic                 wr_overflow;
    logic [630:0]         snap;

    int n_chk  = 0;
    int n_fail = 0;

    bit [1:0] hf_m;
    bit       wh_m;
    bit       rh_m;
    bit       ovf_m;
    int       wcnt_m [NR];

    act_buff_ctrl dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row),
        .wr_data(wr_data), .wr_last(wr_last),
        .rd_start(rd_start), .rd_len(rd_len),
        .wEn_AH(wEn_AH), .wAddr(wAddr), .mem_data_in_all_rows(mem_data_in_all_rows),
        .rEn_AH(rEn_AH), .rAddr(rAddr), .act_valid(act_valid),
        .rd_busy(rd_busy), .rd_done(rd_done), .half_full(half_full),
        .wr_overflow(wr_overflow)
    );

    always #5 clk = ~clk;

    assign snap = {wr_ready, wEn_AH, wAddr, mem_data_in_all_rows, rEn_AH, rAddr,
                   act_valid, rd_busy, rd_done, half_full, wr_overflow};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        hf_m  = 2'b00;
        wh_m  = 1'b0;
        rh_m  = 1'b0;
        ovf_m = 1'b0;
        for (int r = 0; r < NR; r++) wcnt_m[r] = 0;
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        rd_start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic write_word(input int row, input logic [DW-1:0] data, input bit last);
        bit           exp_rdy;
        bit           exp_en;
        int           exp_addr;
        logic [NR-1:0] exp_w;
        exp_rdy  = !hf_m[wh_m];
        exp_en   = exp_rdy && (wcnt_m[row] < HD);
        exp_addr = int'(wh_m) * HD + wcnt_m[row];
        wr_valid = 1'b1;
        wr_row   = 4'(row);
        wr_data  = data;
        wr_last  = last;
        n_chk++;
        if (wr_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL wr_ready: got %b want %b", wr_ready, exp_rdy);
        end
        tick();
        if (exp_rdy) begin
            if (wcnt_m[row] >= HD) ovf_m = 1'b1;
            else wcnt_m[row]++;
            if (last) begin
                hf_m[wh_m] = 1'b1;
                for (int r = 0; r < NR; r++) wcnt_m[r] = 0;
                wh_m = !wh_m;
            end
        end
        exp_w = exp_en ? (NR'(1) << row) : '0;
        n_chk++;
        if (wEn_AH !== exp_w) begin
            n_fail++;
            $display("FAIL wEn_AH: got %h want %h", wEn_AH, exp_w);
        end
        if (exp_en) begin
            n_chk++;
            if (wAddr[row*AW +: AW] !== AW'(exp_addr) || mem_data_in_all_rows[DW-1:0] !== data) begin
                n_fail++;
                $display("FAIL wAddr/data row %0d: got %0d/%h want %0d/%h", row,
                         wAddr[row*AW +: AW], mem_data_in_all_rows[DW-1:0], exp_addr, data);
            end
        end
        n_chk++;
        if (wr_overflow !== ovf_m) begin
            n_fail++;
            $display("FAIL wr_overflow: got %b want %b", wr_overflow, ovf_m);
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    // Cycle 0 is the current cycle (rd_start or committing write already driven).
    task automatic check_stream(input int len, input int first, input bit chk_wr);
        int              base;
        bit              en;
        logic [AW-1:0]   a;
        base = int'(rh_m) * HD;
        for (int c = 1; c <= first + len + 4; c++) begin
            tick();
            if (c == 1) rd_start = 1'b0;
            en = (c >= first) && (c < first + len);
            if (c == first + len) begin
                hf_m[rh_m] = 1'b0;
                rh_m = !rh_m;
            end
            n_chk++;
            if (rEn_AH !== (en ? {NR{1'b1}} : {NR{1'b0}})) begin
                n_fail++;
                $display("FAIL rEn_AH cyc %0d: got %h want %b", c, rEn_AH, en);
            end
            if (en) begin
                a = AW'(base + c - first);
                n_chk++;
                if (rAddr !== {NR{a}}) begin
                    n_fail++;
                    $display("FAIL rAddr cyc %0d: got %0d want %0d", c, rAddr[AW-1:0], a);
                end
            end
            n_chk++;
            if (act_valid !== ((c >= first + 2) && (c < first + len + 2))) begin
                n_fail++;
                $display("FAIL act_valid cyc %0d: got %b", c, act_valid);
            end
            n_chk++;
            if (rd_done !== (c == first + len + 2)) begin
                n_fail++;
                $display("FAIL rd_done cyc %0d: got %b", c, rd_done);
            end
            n_chk++;
            if (rd_busy !== (c < first + len + 2)) begin
                n_fail++;
                $display("FAIL rd_busy cyc %0d: got %b", c, rd_busy);
            end
            if (c == first + len) begin
                n_chk++;
                if (half_full !== hf_m) begin
                    n_fail++;
                    $display("FAIL half_full release: got %b want %b", half_full, hf_m);
                end
            end
            if (chk_wr) begin
                n_chk++;
                if (wr_ready !== !hf_m[wh_m]) begin
                    n_fail++;
                    $display("FAIL wr_ready stream cyc %0d: got %b want %b", c, wr_ready, !hf_m[wh_m]);
                end
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_chk++;
        if (snap !== RST_VEC) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", snap, RST_VEC);
        end
    endtask

    task automatic test_basic();
        apply_reset();
        for (int r = 0; r < NR; r++)
            for (int k = 0; k < 4; k++)
                write_word(r, DW'($urandom), (r == NR - 1) && (k == 3));
        n_chk++;
        if (half_full !== 2'b01) begin
            n_fail++;
            $display("FAIL basic half_full: got %b want 01", half_full);
        end
        rd_start = 1'b1;
        rd_len   = 9'd4;
        check_stream(4, 2, 1'b1);
    endtask

    task automatic test_ping_pong();
        int l1;
        int l2;
        apply_reset();
        for (int i = 0; i < 8; i++) write_word($urandom_range(0, NR - 1), DW'($urandom), i == 7);
        l1 = $urandom_range(20, 60);
        rd_start = 1'b1;
        rd_len   = LW'(l1);
        fork
            check_stream(l1, 2, 1'b0);
            for (int i = 0; i < 30; i++) write_word($urandom_range(0, NR - 1), DW'($urandom), 1'b0);
        join
        write_word($urandom_range(0, NR - 1), DW'($urandom), 1'b1);
        l2 = $urandom_range(1, 200);
        rd_start = 1'b1;
        rd_len   = LW'(l2);
        check_stream(l2, 2, 1'b1);
    endtask

    task automatic test_fill_both();
        apply_reset();
        write_word($urandom_range(0, NR - 1), DW'($urandom), 1'b1);
        write_word($urandom_range(0, NR - 1), DW'($urandom), 1'b1);
        for (int i = 0; i < 3; i++) write_word($urandom_range(0, NR - 1), DW'($urandom), 1'b0);
        n_chk++;
        if (half_full !== 2'b11) begin
            n_fail++;
            $display("FAIL fill_both half_full: got %b want 11", half_full);
        end
        rd_start = 1'b1;
        rd_len   = 9'd450;
        check_stream(HD, 2, 1'b1);
        write_word($urandom_range(0, NR - 1), DW'($urandom), 1'b0);
    endtask

    task automatic test_wait_commit();
        apply_reset();
        rd_start = 1'b1;
        rd_len   = 9'd0;
        tick();
        rd_start = 1'b0;
        n_chk++;
        if (rd_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len busy: got %b want 0", rd_busy);
        end
        rd_start = 1'b1;
        rd_len   = 9'd5;
        tick();
        rd_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_chk++;
            if (rEn_AH !== '0 || rd_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL wait_empty: rEn %h busy %b want 0000 1", rEn_AH, rd_busy);
            end
        end
        fork
            write_word($urandom_range(0, NR - 1), DW'($urandom), 1'b1);
            check_stream(5, 2, 1'b0);
        join
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < HD + 1; i++) write_word(3, DW'($urandom), 1'b0);
        for (int i = 0; i < 4; i++) write_word($urandom_range(4, NR - 1), DW'($urandom), i == 3);
        n_chk++;
        if (wr_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky: got %b want 1", wr_overflow);
        end
        apply_reset();
        n_chk++;
        if (wr_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_clear: got %b want 0", wr_overflow);
        end
    endtask

    task automatic test_reset_mid_read();
        int l;
        apply_reset();
        write_word($urandom_range(0, NR - 1), DW'($urandom), 1'b1);
        rd_start = 1'b1;
        rd_len   = 9'd300;
        tick();
        rd_start = 1'b0;
        repeat (100) tick();
        n_chk++;
        if (rEn_AH !== {NR{1'b1}} || rAddr[AW-1:0] !== 10'd99) begin
            n_fail++;
            $display("FAIL mid_read: rEn %h rAddr %0d want ffff 99", rEn_AH, rAddr[AW-1:0]);
        end
        rst = 1'b1;
        #1;
        n_chk++;
        if (snap !== RST_VEC) begin
            n_fail++;
            $display("FAIL async_reset: got %h want %h", snap, RST_VEC);
        end
        tick();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            tick();
            n_chk++;
            if (act_valid !== 1'b0 || rEn_AH !== '0 || rd_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset: act_valid %b rEn %h busy %b want 0", act_valid, rEn_AH, rd_busy);
            end
        end
        write_word($urandom_range(0, NR - 1), DW'($urandom), 1'b1);
        l = $urandom_range(1, 50);
        rd_start = 1'b1;
        rd_len   = LW'(l);
        check_stream(l, 2, 1'b1);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_ping_pong();
        test_fill_both();
        test_wait_commit();
        test_overflow();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/act_buff_ctrl.md
# act_buff_ctrl

Ping-pong scheduler for the per-row activation buffer SRAM bank (16 rows × 768 × 17 b, registered read data). Splits each row's SRAM into two halves of 384 words. A loader fills one half while the PE array streams the other. It generates the active-high per-row write/read enables and addresses, and registers the write data. It also flags when registered buffer data reaching the PE array is valid.

## Interface
- nb_pe_row, 16, PE rows = SRAM instances
- compressed_act_width, 17, SRAM word width
- mem_depth, 768, words per row SRAM; must be even
- half_depth, mem_depth/2, words per ping-pong half
- addr_width, clogb2(mem_depth), SRAM address width
- len_width, clogb2(half_depth+1), read-length width
- row_width, clogb2(nb_pe_row), row index width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wr_valid  in  1  loader word valid
- wr_ready  out  1  controller accepts loader word
- wr_row  in  row_width  target row of word
- wr_data  in  compressed_act_width  loader word
- wr_last  in  1  final word of tile; commits fill half
- rd_start  in  1  one-cycle pulse; begin tile stream
- rd_len  in  len_width  words per row to stream, sampled with rd_start
- wEn_AH  out  nb_pe_row  registered per-row write enable
- wAddr  out  nb_pe_row×addr_width  registered per-row write address
- mem_data_in_all_rows  out  nb_pe_row×compressed_act_width  registered write data, broadcast to all rows
- rEn_AH  out  nb_pe_row  registered read enable, all bits equal
- rAddr  out  nb_pe_row×addr_width  registered read address, all rows equal
- act_valid  out  1  buffer's registered output holds valid data this cycle
- rd_busy  out  1  read FSM not IDLE
- rd_done  out  1  one-cycle pulse after last act_valid
- half_full  out  2  per-half FULL flag
- wr_overflow  out  1  sticky error flag

## Operation
- Per-half state is EMPTY or FULL. Both halves reset to EMPTY.
- Pointers wr_half and rd_half reset to 0. Half h has base address h×half_depth.
- Write side:
  - wr_ready = (half[wr_half]==EMPTY).
  - A handshake is wr_valid & wr_ready.
  - On a handshake, per-row counter wcnt[wr_row] supplies the address wr_half×half_depth + wcnt[wr_row]. The counter then increments.
  - If wcnt[wr_row]==half_depth, the word is dropped (no wEn_AH) and wr_overflow is set. wr_overflow clears only on rst.
  - A handshake with wr_last marks half[wr_half] FULL, clears all wcnt, and toggles wr_half. The word itself is still written, subject to the overflow rule.
- Read FSM states:
  - IDLE: on rd_start, latch rd_len, then go to WAIT. rd_len==0 means rd_start is ignored. rd_len>half_depth is clamped to half_depth.
  - WAIT: go to READ when half[rd_half]==FULL.
  - READ: issue one address per cycle, rd_half×half_depth + rcnt, for rcnt=0..len-1. On the last issue, go to DRAIN.
  - DRAIN: hold until the last act_valid, pulse rd_done, then go to IDLE.
- rd_start outside IDLE is ignored.
- Half release: half[rd_half] becomes EMPTY and rd_half toggles on the clock edge that ends the cycle in which rEn_AH is high for the last address. The SRAM samples that read on the same edge, so a write to the freed half is never seen by the read.
- Simultaneous events:
  - Commit and WAIT on the same half: READ is entered the cycle after the commit.
  - Release and a wr_ready-gated loader on the same half: wr_ready rises the cycle after the release.

## Timing
- Write: a handshake in cycle t gives wEn_AH[row], wAddr[row] and mem_data_in_all_rows high/valid in t+1. Only one wEn_AH bit is high per cycle.
- Read: in the FSM READ cycle t, rEn_AH=all-ones and rAddr are valid in t+1. The SRAM Q appears in t+2 and the buffer register in t+3. act_valid is high in t+3, exactly 2 cycles after each rEn_AH cycle.
- Back-to-back: one read per cycle with no bubbles for len cycles. rd_done is high in the cycle after the last act_valid.
- rd_start to first rEn_AH takes 2 cycles when the half is already FULL.
- Reset values: wr_ready=1, all wEn_AH/rEn_AH=0, all addresses and data=0, act_valid=0, rd_busy=0, rd_done=0, half_full=00, wr_overflow=0.
- Asserting rst mid-operation clears everything immediately. The act_valid pipeline is flushed, so no act_valid appears after reset.

## Test plan
- Fill half 0 with 4 words to each of rows 0..15, wr_last on the final word, then rd_start rd_len=4 → rAddr 0,1,2,3 on consecutive cycles, act_valid for 4 cycles starting 2 cycles after the first rEn_AH, rd_done once, half_full=00.
- Ping-pong: commit half 0, then stream it while writing half 1 (wAddr base 384) → no wr_ready stall. The second read uses rAddr 384..384+len-1.
- Fill both halves without reading → wr_ready=0 and wr_valid ignored. Start a read → wr_ready rises the cycle after the last rEn_AH, and the next write goes to wAddr 0.
- rd_start with both halves EMPTY → FSM stays in WAIT with rEn_AH=0. Commit half 0 → first rEn_AH 2 cycles after the commit handshake.
- Write 385 words to row 3 of one half → the 385th word produces no wEn_AH, and wr_overflow stays 1 until rst.
- Assert rst during READ at rcnt=100 → all outputs return to reset values at once, with no act_valid afterwards. Streaming works again after refill.
